// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// response multiplexer and its default slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_ERR1 = 2'b01,
        D_ERR2 = 2'b10
    } def_state_t;

    // NONSEQ and SEQ are the only transfer types that demand a response.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle
// ERROR response and is transparently OKAY otherwise.
//
// state  | meaning
// D_IDLE | no error pending; ready, OKAY
// D_ERR1 | first error cycle; wait state, ERROR
// D_ERR2 | second error cycle; ready, ERROR
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic HREADY,
    input  logic unmapped_req,
    output logic def_ready,
    output logic def_resp
);

    def_state_t state, state_nxt;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= D_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        def_ready = 1'b1;
        def_resp  = HRESP_OKAY;
        case (state)
            D_IDLE: begin
                if (HREADY && unmapped_req) begin
                    state_nxt = D_ERR1;
                end
            end
            D_ERR1: begin
                def_ready = 1'b0;
                def_resp  = HRESP_ERROR;
                state_nxt = D_ERR2;
            end
            D_ERR2: begin
                def_resp = HRESP_ERROR;
                // The second error cycle is also an accepting cycle.
                if (HREADY && unmapped_req) begin
                    state_nxt = D_ERR1;
                end else begin
                    state_nxt = D_IDLE;
                end
            end
            default: begin
                state_nxt = D_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_response_mux.sv
// N-slave AHB-Lite response multiplexer: registers the address-phase select
// on each accepted transfer and routes ready/response/data in the data phase.
module ahb_response_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [1:0]                       HTRANS,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    output logic                             HREADY,
    output logic                             HRESP,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HSEL_ERR
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic             own_slave;
    logic [IDX_W-1:0] own_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             sel_multi;
    logic             unmapped_req;
    logic             def_ready;
    logic             def_resp;
    logic             hsel_err_q;

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (HSEL[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_any      = |HSEL;
    assign sel_multi    = |(HSEL & (HSEL - NUM_SLAVES'(1)));
    assign unmapped_req = !sel_any && is_active(HTRANS);

    // When no slave owns the data phase, the default slave FSM decides
    // between the OKAY and ERROR flavours of the default response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            own_slave  <= 1'b0;
            own_idx    <= '0;
            hsel_err_q <= 1'b0;
        end else if (HREADY) begin
            own_slave <= sel_any;
            own_idx   <= sel_idx;
            if (sel_multi) begin
                hsel_err_q <= 1'b1;
            end
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HREADY       (HREADY),
        .unmapped_req (unmapped_req),
        .def_ready    (def_ready),
        .def_resp     (def_resp)
    );

    always_comb begin
        HREADY = def_ready;
        HRESP  = def_resp;
        HRDATA = '0;
        if (own_slave) begin
            HREADY = 1'b1;
            HRESP  = HRESP_OKAY;
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (own_idx == IDX_W'(i)) begin
                    HREADY = HREADYOUT[i];
                    HRESP  = HRESP_S[i];
                    HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign HSEL_ERR = hsel_err_q;

endmodule

// File: tb/tb_ahb_response_mux.sv
// Directed bench for ahb_response_mux with three 64-bit slaves.
module tb_ahb_response_mux;
    import ahb_pkg::*;

    localparam int NS = 3;
    localparam int DW = 64;

    localparam logic [DW-1:0] D0 = 64'h0000_0000_0000_1111;
    localparam logic [DW-1:0] D1 = 64'hABCD_EF12_3456_7890;
    localparam logic [DW-1:0] D2 = 64'h2222_3333_4444_5555;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [NS-1:0]    HSEL;
    logic [1:0]       HTRANS;
    logic [NS-1:0]    HREADYOUT;
    logic [NS-1:0]    HRESP_S;
    logic [NS*DW-1:0] HRDATA_S;
    logic             HREADY;
    logic             HRESP;
    logic [DW-1:0]    HRDATA;
    logic             HSEL_ERR;

    int checks = 0;
    int errors = 0;

    ahb_response_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HREADYOUT (HREADYOUT),
        .HRESP_S   (HRESP_S),
        .HRDATA_S  (HRDATA_S),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .HSEL_ERR  (HSEL_ERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESET    = 1'b1;
        HSEL      = '0;
        HTRANS    = HTRANS_IDLE;
        HREADYOUT = '0;
        HRESP_S   = '0;
        HRDATA_S  = '0;
        tick();
        tick();
        #1;
        chk("rst_hready", 64'(HREADY), 64'd1);
        chk("rst_hresp", 64'(HRESP), 64'd0);
        chk("rst_hrdata", HRDATA, 64'd0);
        chk("rst_hsel_err", 64'(HSEL_ERR), 64'd0);

        HRESET    = 1'b0;
        HREADYOUT = 3'b111;
        HRDATA_S  = {D2, D1, D0};

        // Single read from slave 1
        HSEL = 3'b010; HTRANS = HTRANS_NONSEQ;
        tick();
        HSEL = 3'b000; HTRANS = HTRANS_IDLE;
        #1;
        chk("s1_hrdata", HRDATA, D1);
        chk("s1_hready", 64'(HREADY), 64'd1);
        chk("s1_hresp", 64'(HRESP), 64'd0);
        tick();

        // Slave 2 with three wait states; HSEL change during waits is ignored
        HSEL = 3'b100; HTRANS = HTRANS_NONSEQ;
        tick();
        HREADYOUT = 3'b011; HSEL = 3'b001; HTRANS = HTRANS_NONSEQ;
        #1;
        chk("wait1_hready", 64'(HREADY), 64'd0);
        chk("wait1_hrdata", HRDATA, D2);
        tick();
        chk("wait2_hready", 64'(HREADY), 64'd0);
        tick();
        chk("wait3_hready", 64'(HREADY), 64'd0);
        chk("wait3_hrdata", HRDATA, D2);
        HREADYOUT = 3'b111; HSEL = 3'b000; HTRANS = HTRANS_IDLE;
        #1;
        chk("wait_end_hready", 64'(HREADY), 64'd1);
        chk("wait_end_hrdata", HRDATA, D2);
        tick();
        chk("after_wait_hrdata", HRDATA, 64'd0);
        chk("after_wait_hready", 64'(HREADY), 64'd1);

        // Unmapped NONSEQ -> two-cycle ERROR
        HTRANS = HTRANS_NONSEQ;
        tick();
        HTRANS = HTRANS_IDLE;
        #1;
        chk("err1_hready", 64'(HREADY), 64'd0);
        chk("err1_hresp", 64'(HRESP), 64'd1);
        chk("err1_hrdata", HRDATA, 64'd0);
        tick();
        chk("err2_hready", 64'(HREADY), 64'd1);
        chk("err2_hresp", 64'(HRESP), 64'd1);
        tick();
        chk("err_done_hready", 64'(HREADY), 64'd1);
        chk("err_done_hresp", 64'(HRESP), 64'd0);
        tick();
        chk("idle_hready", 64'(HREADY), 64'd1);
        chk("idle_hresp", 64'(HRESP), 64'd0);

        // Unmapped SEQ accepted in ERR2 restarts the error sequence
        HTRANS = HTRANS_SEQ;
        tick();
        tick();
        chk("seq_err2_hresp", 64'(HRESP), 64'd1);
        chk("seq_err2_hready", 64'(HREADY), 64'd1);
        tick();
        HTRANS = HTRANS_IDLE;
        #1;
        chk("seq_reerr1_hready", 64'(HREADY), 64'd0);
        chk("seq_reerr1_hresp", 64'(HRESP), 64'd1);
        tick();
        tick();
        chk("seq_done_hresp", 64'(HRESP), 64'd0);

        // Multiple HSEL bits: lowest index wins, sticky error flag
        HSEL = 3'b110; HTRANS = HTRANS_NONSEQ;
        tick();
        HSEL = 3'b000; HTRANS = HTRANS_IDLE;
        #1;
        chk("multi_hrdata", HRDATA, D1);
        chk("multi_hsel_err", 64'(HSEL_ERR), 64'd1);
        tick();
        chk("multi_sticky", 64'(HSEL_ERR), 64'd1);
        chk("multi_after_hrdata", HRDATA, 64'd0);

        // Slave ERROR passes through
        HSEL = 3'b001; HTRANS = HTRANS_NONSEQ;
        tick();
        HSEL = 3'b000; HTRANS = HTRANS_IDLE; HRESP_S = 3'b001;
        #1;
        chk("slv_err_hresp", 64'(HRESP), 64'd1);
        HRESP_S = 3'b000;
        tick();

        // Reset during ERR1
        HTRANS = HTRANS_NONSEQ;
        tick();
        chk("pre_rst_err1_hready", 64'(HREADY), 64'd0);
        HRESET = 1'b1; HTRANS = HTRANS_IDLE;
        tick();
        chk("rst_err1_hready", 64'(HREADY), 64'd1);
        chk("rst_err1_hresp", 64'(HRESP), 64'd0);
        chk("rst_err1_hsel_err", 64'(HSEL_ERR), 64'd0);
        chk("rst_err1_hrdata", HRDATA, 64'd0);
        HRESET = 1'b0;
        tick();

        // Back-to-back slave0 -> slave2
        HSEL = 3'b001; HTRANS = HTRANS_NONSEQ;
        tick();
        HSEL = 3'b100; HTRANS = HTRANS_NONSEQ;
        #1;
        chk("b2b_s0_hrdata", HRDATA, D0);
        tick();
        HSEL = 3'b000; HTRANS = HTRANS_IDLE;
        #1;
        chk("b2b_s2_hrdata", HRDATA, D2);
        chk("b2b_s2_hready", 64'(HREADY), 64'd1);
        tick();
        chk("b2b_end_hrdata", HRDATA, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
